register_sipo_rx: RTL and testbench
===================================

Name: register_sipo_rx

Overview:
- Serial-in, parallel-out receiver; the far end of the 4-bit parallel-load, serial-shift transmitter register.
- Accepts one bit per qualified clock, LSB first, and assembles WIDTH-bit words.
- Presents each completed word on a valid/ready output port, with a one-word holding register and a sticky overrun flag.
- Sits between a serial link and the parallel consumer logic.

Parameters:
- WIDTH, 4, data word width in bits (≥2).

Ports:
- clk       input   1        system clock; all state changes on rising edge.
- reset     input   1        asynchronous, active-high reset.
- s_in      input   1        serial data bit.
- s_valid   input   1        s_in is a valid bit this cycle.
- s_sync    input   1        with s_valid: this bit is bit 0 of a new word.
- pd_out    output  WIDTH    assembled word; bit 0 = first bit received.
- pd_valid  output  1        pd_out holds an unconsumed word.
- pd_ready  input   1        consumer accepts pd_out this cycle.
- busy      output  1        partial word in progress (state SHIFT).
- overrun   output  1        sticky: a completed word was dropped.
- ovr_clr   input   1        synchronous clear of overrun.
- par_err   output  1        parity error for the word on pd_out (see Optional Feature).

Behaviour:
- Reset (async, active-high, one clock `clk`): shift register 0, bit counter 0, state IDLE, pd_out 0, pd_valid 0, busy 0, overrun 0, par_err 0. Reset asserted mid-word discards the partial word and any held word.
- State machine:
  - IDLE → SHIFT on s_valid (s_sync is irrelevant in IDLE).
  - SHIFT → IDLE on the cycle the last bit is taken.
  - SHIFT with s_valid&s_sync: restart; the partial word is discarded and this bit becomes bit 0, counter = 1.
  - busy = (state == SHIFT).
- Shift: on s_valid, sh <= {s_in, sh[WIDTH-1:1]}; counter +1. The first bit received ends in sh[0].
- s_sync without s_valid is ignored. No s_valid means no shift and no count; gaps of any length are allowed.
- Completion: the s_valid cycle with counter == WIDTH-1 completes a word (assembled value = {s_in, sh[WIDTH-1:1]}). Counter returns to 0.
- Latency: pd_valid rises on the clock edge that samples the final bit, i.e. visible in the next cycle.
- Handshake:
  - A transfer occurs when pd_valid&pd_ready. pd_valid clears after a transfer unless a new word loads in the same edge.
  - pd_out is stable while pd_valid=1 and pd_ready=0.
- Simultaneous completion and pd_ready with pd_valid=1: the new word loads and pd_valid stays 1; no overrun.
- Completion while pd_valid=1 and pd_ready=0: the new word is dropped, pd_out unchanged, overrun <= 1.
- overrun is cleared only by reset or ovr_clr. If ovr_clr and a new overrun occur in the same cycle, set wins.
- pd_ready while pd_valid=0 has no effect.
- Back-to-back words are allowed: bit 0 of the next word may arrive the cycle after the last bit of the previous word.

Optional Feature:
- Macro RX_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit; completion occurs on the parity bit (counter reaches WIDTH).
  - The parity bit is not stored in pd_out.
  - par_err = XOR(data bits, parity bit); it loads with pd_out and is held alongside it.
  - A word with a parity error is still delivered.
  - s_sync on the parity-bit slot restarts as normal.
- Undefined: words are WIDTH bits and par_err is tied 0. The port is present in both builds.

Decomposition:
- Package register_pkg:
  - state encoding (IDLE=0, SHIFT=1);
  - function clog2 for counter width;
  - localparam for frame length (WIDTH or WIDTH+1).
- Sub-module register_sipo_core: shift register, bit counter and sync/restart logic; outputs word_done and assembled word.
- Top level: output holding register, handshake, overrun, parity.

Test Plan:
- Word receive: WIDTH=4, reset, pd_ready=1; s_valid bits 1,0,1,1 (s_sync on first) → pd_valid=1 one cycle after 4th bit, pd_out=4'hD, busy 1→0.
- Backpressure/overrun: pd_ready=0; send 4'h3, then 4'hA → after the second word pd_out still 4'h3, overrun=1. ovr_clr for 1 cycle → overrun=0.
- Simultaneous: pd_valid=1 holding 4'h5; pd_ready=1 on the edge the last bit of 4'h9 is sampled → next cycle pd_valid=1, pd_out=4'h9, overrun=0.
- Resync and gaps: send bits 1,1, idle 3 cycles, then s_sync bits 0,1,0,0 → pd_out=4'h2; partial bits discarded.
- Reset mid-word: two bits in, assert reset 1 cycle → busy=0, pd_valid=0; then a full word 4'hF is received correctly.
- RX_PARITY_EN: data 1,0,1,1 + parity 1 → pd_out=4'hD, par_err=0; same data + parity 0 → par_err=1, word still delivered.

Source files
------------

// File: rtl/register_sipo_rx_pkg.sv
// Shared types and helpers for the serial-in, parallel-out receiver.
// Build option RX_PARITY_EN appends one even-parity bit to every frame.
package register_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Serial slots per word: data bits plus the optional parity slot.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

    function automatic logic parity_of(input logic [31:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/register_sipo_rx_if.sv
// Serial input and parallel valid/ready output bundle of the receiver.
// master = receiver side, slave = link driver plus consumer.
interface register_sipo_rx_if #(
    parameter int WIDTH = 4
);
    logic             s_in;
    logic             s_valid;
    logic             s_sync;
    logic [WIDTH-1:0] pd_out;
    logic             pd_valid;
    logic             pd_ready;
    logic             busy;
    logic             overrun;
    logic             ovr_clr;
    logic             par_err;

    modport master (
        input  s_in, s_valid, s_sync, pd_ready, ovr_clr,
        output pd_out, pd_valid, busy, overrun, par_err
    );

    modport slave (
        output s_in, s_valid, s_sync, pd_ready, ovr_clr,
        input  pd_out, pd_valid, busy, overrun, par_err
    );
endinterface

// File: rtl/register_sipo_core.sv
// Shift register, bit counter and sync/restart control of the receiver.
// Flags word_done for one cycle with the full frame (first bit in word[0]).
module register_sipo_core
    import register_pkg::*;
#(
    parameter int FRAME = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_sync,
    output logic             word_done,
    output logic [FRAME-1:0] word,
    output logic             busy
);
    localparam int CW = clog2(FRAME);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    state_t          state_r;
    state_t          state_nx_s;
    logic [FRAME-1:0] sh_r;
    logic [CW-1:0]   cnt_r;
    logic            restart_s;
    logic            done_s;

    // A sync bit mid-word discards the partial word; it never completes one.
    assign restart_s = s_valid & s_sync & (state_r == SHIFT);
    assign done_s    = s_valid & ~restart_s & (cnt_r == LAST_IDX);
    assign word      = {s_in, sh_r[FRAME-1:1]};
    assign word_done = done_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (s_valid) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        case (state_r)
            SHIFT:   busy = 1'b1;
            IDLE:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    // Shift register and bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_r  <= '0;
            cnt_r <= '0;
        end else if (s_valid) begin
            sh_r <= {s_in, sh_r[FRAME-1:1]};
            if (restart_s) begin
                cnt_r <= CW'(1);
            end else if (done_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/register_sipo_rx.sv
// Serial-to-parallel receiver: one-word holding register, valid/ready output,
// sticky overrun. Define RX_PARITY_EN for a trailing even-parity bit per word.
module register_sipo_rx
    import register_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    register_sipo_rx_if.master  bus
);
    localparam int FRAME = frame_len(WIDTH);

    logic             word_done_s;
    logic [FRAME-1:0] word_s;
    logic             busy_s;
    logic             par_s;
    logic             load_s;
    logic             drop_s;
    logic [WIDTH-1:0] pd_r;
    logic             valid_r;
    logic             ovr_r;
    logic             perr_r;

    register_sipo_core #(.FRAME(FRAME)) u_core (
        .clk       (clk),
        .reset     (reset),
        .s_in      (bus.s_in),
        .s_valid   (bus.s_valid),
        .s_sync    (bus.s_sync),
        .word_done (word_done_s),
        .word      (word_s),
        .busy      (busy_s)
    );

`ifdef RX_PARITY_EN
    assign par_s = parity_of(32'(word_s));
`else
    assign par_s = 1'b0;
`endif

    // The holding slot is free if empty or being consumed on this same edge.
    assign load_s = word_done_s & (~valid_r | bus.pd_ready);
    assign drop_s = word_done_s & valid_r & ~bus.pd_ready;

    // Holding register, handshake and overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pd_r    <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (load_s) begin
                pd_r    <= word_s[WIDTH-1:0];
                perr_r  <= par_s;
                valid_r <= 1'b1;
            end else if (valid_r & bus.pd_ready) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                ovr_r <= 1'b1;
            end else if (bus.ovr_clr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign bus.pd_out   = pd_r;
    assign bus.pd_valid = valid_r;
    assign bus.par_err  = perr_r;
    assign bus.overrun  = ovr_r;
    assign bus.busy     = busy_s;

endmodule

// File: tb/tb_register_sipo_rx.sv
// Scoreboard bench for register_sipo_rx: expected words are queued as sent and
// matched on each valid&ready transfer; direct checks cover flags and timing.
module tb_register_sipo_rx;
    localparam int W = 4;
`ifdef RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_sipo_rx_if #(.WIDTH(W)) bus ();
    register_sipo_rx #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [W:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sync);
        bus.s_in = b;
        bus.s_valid = 1'b1;
        bus.s_sync = sync;
        tick();
        bus.s_valid = 1'b0;
        bus.s_sync = 1'b0;
    endtask

    // Optionally raises pd_ready just before the final slot of the frame.
    task automatic send_word(input logic [W-1:0] d, input bit bad, input bit ready_on_last);
        for (int i = 0; i < W; i++) begin
            if (!PAR && ready_on_last && i == W - 1) bus.pd_ready = 1'b1;
            send_bit(d[i], (i == 0));
        end
        if (PAR) begin
            if (ready_on_last) bus.pd_ready = 1'b1;
            send_bit((^d) ^ bad, 1'b0);
        end
    endtask

    task automatic expect_word(input logic [W-1:0] d, input bit bad);
        sb_q.push_back({(PAR ? bad : 1'b0), d});
    endtask

    // Every valid&ready seen here is a transfer on the following rising edge.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.pd_valid === 1'b1 && bus.pd_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", {27'd0, bus.par_err, bus.pd_out}, 32'hFFFF_FFFF);
            end else begin
                check("sb_word", {27'd0, bus.par_err, bus.pd_out}, {27'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.s_in = 1'b0; bus.s_valid = 1'b0; bus.s_sync = 1'b0;
        bus.pd_ready = 1'b0; bus.ovr_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_pd_valid", 32'(bus.pd_valid), 32'd0);
        check("rst_pd_out", 32'(bus.pd_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_par_err", 32'(bus.par_err), 32'd0);

        // Plain word 4'hD with latency and busy
        bus.pd_ready = 1'b1;
        expect_word(4'hD, 1'b0);
        send_bit(1'b1, 1'b1);
        check("word_busy_hi", 32'(bus.busy), 32'd1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        if (PAR) begin
            send_bit(1'b1, 1'b0);
            check("par_not_done_yet", 32'(bus.pd_valid), 32'd0);
            send_bit(1'b1, 1'b0);
        end else begin
            check("word_not_done_yet", 32'(bus.pd_valid), 32'd0);
            send_bit(1'b1, 1'b0);
        end
        check("word_valid", 32'(bus.pd_valid), 32'd1);
        check("word_out", 32'(bus.pd_out), 32'hD);
        check("word_busy_lo", 32'(bus.busy), 32'd0);
        check("word_par_err", 32'(bus.par_err), 32'd0);
        tick();
        check("word_consumed", 32'(bus.pd_valid), 32'd0);

        // Backpressure and overrun
        bus.pd_ready = 1'b0;
        expect_word(4'h3, 1'b0);
        send_word(4'h3, 1'b0, 1'b0);
        check("bp_valid", 32'(bus.pd_valid), 32'd1);
        send_word(4'hA, 1'b0, 1'b0);
        check("bp_held_out", 32'(bus.pd_out), 32'h3);
        check("bp_overrun", 32'(bus.overrun), 32'd1);
        tick();
        check("bp_overrun_sticky", 32'(bus.overrun), 32'd1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        check("ovr_cleared", 32'(bus.overrun), 32'd0);
        bus.pd_ready = 1'b1;
        tick();
        check("bp_drained", 32'(bus.pd_valid), 32'd0);

        // Completion on the same edge as a transfer
        bus.pd_ready = 1'b0;
        expect_word(4'h5, 1'b0);
        send_word(4'h5, 1'b0, 1'b0);
        expect_word(4'h9, 1'b0);
        send_word(4'h9, 1'b0, 1'b1);
        check("simul_valid", 32'(bus.pd_valid), 32'd1);
        check("simul_out", 32'(bus.pd_out), 32'h9);
        check("simul_overrun", 32'(bus.overrun), 32'd0);
        tick();

        // Partial word, gap (with a lone sync), then resync
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        bus.s_sync = 1'b1;
        tick();
        bus.s_sync = 1'b0;
        tick(); tick();
        check("gap_busy", 32'(bus.busy), 32'd1);
        check("gap_no_word", 32'(bus.pd_valid), 32'd0);
        expect_word(4'h2, 1'b0);
        send_word(4'h2, 1'b0, 1'b0);
        check("resync_out", 32'(bus.pd_out), 32'h2);
        tick();

        // Back-to-back words
        expect_word(4'h7, 1'b0);
        expect_word(4'hC, 1'b0);
        send_word(4'h7, 1'b0, 1'b0);
        send_word(4'hC, 1'b0, 1'b0);
        check("b2b_out", 32'(bus.pd_out), 32'hC);
        tick();

        // Parity error word is still delivered
        expect_word(4'hD, 1'b1);
        send_word(4'hD, 1'b1, 1'b0);
        check("perr_flag", 32'(bus.par_err), (PAR ? 32'd1 : 32'd0));
        check("perr_out", 32'(bus.pd_out), 32'hD);
        tick();

        // Reset mid-word discards held and partial words
        bus.pd_ready = 1'b0;
        send_word(4'h6, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_valid", 32'(bus.pd_valid), 32'd0);
        tick();
        reset = 1'b0;
        bus.pd_ready = 1'b1;
        expect_word(4'hF, 1'b0);
        send_word(4'hF, 1'b0, 1'b0);
        check("post_rst_out", 32'(bus.pd_out), 32'hF);
        tick(); tick(); tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
